serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing diff = a - b - b_in, LSB first, one bit per clock.
- Datapath is a single full-subtractor cell with a registered borrow, plus shift registers.
- Sits beside the combinational adders as the area-cheap inverse operation.
- Controlled by a start/busy/done handshake so a host FSM can sequence operations.

---
 rtl/serial_subtractor.sv | 121 ++++++++++++
 tb/tb_serial_subtractor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - b_in, LSB first, one bit per clock.
// Ports: clk, rst_n, start, a, b, b_in in; busy, done, diff, b_out (+ovf if SERIAL_SUB_OVF_EN) out.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sa, sb, sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             accept, last;
  logic             d, br_nxt;

  // one full-subtractor cell on the current LSBs
  assign d      = sa[0] ^ sb[0] ^ br;
  assign br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      b_out <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        sa  <= a;
        sb  <= b;
        br  <= b_in;
        cnt <= '0;
      end else if (state == SHIFT) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        sr  <= {d, sr[WIDTH-1:1]};
        br  <= br_nxt;
        cnt <= cnt + 1'b1;
        if (last) begin
          diff  <= {d, sr[WIDTH-1:1]};
          b_out <= br_nxt;
          done  <= 1'b1;
        end
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // operand sign bits are shifted out, so keep copies for the final check
  logic a_msb, b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      // d is the result MSB on the last bit
      if (last) ovf <= (a_msb != b_msb) && (d != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for serial_subtractor (WIDTH=8).
// Runs with or without SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         b_in;
  logic         busy, done, b_out;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;
  int dcnt     = 0;

  logic [W-1:0] last_diff;
  logic         last_bout;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) dcnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(logic [W-1:0] ia, logic [W-1:0] ib, logic ibin);
    a     = ia;
    b     = ib;
    b_in  = ibin;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_busy", {63'd0, busy}, 64'd1);
  endtask

  // after accept: WIDTH-1 busy cycles holding old result, then done
  task automatic wait_done(string tag, logic [W-1:0] ed, logic eb);
    for (int i = 1; i < W; i++) begin
      tick();
      chk({tag, "_run"}, {52'd0, busy, done, diff, b_out},
          {52'd0, 1'b1, 1'b0, last_diff, last_bout});
    end
    tick();
    chk({tag, "_done"}, {52'd0, busy, done, diff, b_out},
        {52'd0, 1'b0, 1'b1, ed, eb});
    last_diff = ed;
    last_bout = eb;
  endtask

  initial begin
    logic [W:0] m;
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    b_in  = 1'b0;
    last_diff = '0;
    last_bout = 1'b0;
    tick();
    tick();
    chk("reset", {60'd0, busy, done, diff == 0, b_out}, {60'd0, 4'b0010});
`ifdef SERIAL_SUB_OVF_EN
    chk("reset_ovf", {63'd0, ovf}, 64'd0);
`endif
    rst_n = 1'b1;
    tick();
    chk("idle", {62'd0, busy, done}, 64'd0);

    // 1: 5 - 3
    issue(8'h05, 8'h03, 1'b0);
    wait_done("t1", 8'h02, 1'b0);
    tick();
    chk("t1_done_clr", {63'd0, done}, 64'd0);

    // 2: 0 - 1, then back-to-back 0x10 - 0x10 - 1 from the done cycle
    issue(8'h00, 8'h01, 1'b0);
    wait_done("t2a", 8'hFF, 1'b1);
    issue(8'h10, 8'h10, 1'b1);
    wait_done("t2b", 8'hFF, 1'b1);

    // 3: start held; operands change mid-op
    a     = 8'hA5;
    b     = 8'h5A;
    b_in  = 1'b0;
    start = 1'b1;
    tick();
    chk("t3_busy", {63'd0, busy}, 64'd1);
    a = 8'h00;
    b = 8'hFF;
    wait_done("t3a", 8'h4B, 1'b0);
    tick();
    start = 1'b0;
    chk("t3_b2b_busy", {63'd0, busy}, 64'd1);
    wait_done("t3b", 8'h01, 1'b1);

    // 4: async reset on the 4th SHIFT cycle
    issue(8'h33, 8'h11, 1'b0);
    tick();
    tick();
    tick();
    #2;
    d0 = dcnt;
    rst_n = 1'b0;
    #1;
    chk("t4_async", {52'd0, busy, done, diff, b_out}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("t4_nodone", dcnt - d0, 64'd0);
    chk("t4_idle", {62'd0, busy, done}, 64'd0);
    last_diff = '0;
    last_bout = 1'b0;

`ifdef SERIAL_SUB_OVF_EN
    // 5: signed overflow flag
    issue(8'h80, 8'h01, 1'b0);
    wait_done("t5a", 8'h7F, 1'b0);
    chk("t5a_ovf", {63'd0, ovf}, 64'd1);
    issue(8'h7F, 8'hFF, 1'b0);
    wait_done("t5b", 8'h80, 1'b1);
    chk("t5b_ovf", {63'd0, ovf}, 64'd1);
    issue(8'h05, 8'h03, 1'b0);
    wait_done("t5c", 8'h02, 1'b0);
    chk("t5c_ovf", {63'd0, ovf}, 64'd0);
`endif

    // 6: random operands against a 9-bit reference
    d0 = dcnt;
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      m  = {1'b0, ra} - {1'b0, rb} - {8'd0, rc};
      issue(ra, rb, rc);
      wait_done("rand", m[W-1:0], m[W]);
    end
    tick();
    chk("rand_done_cnt", dcnt - d0, 64'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
